// File: rtl/axi_write_arbiter_pkg.sv
// Shared AXI bus definitions for the write arbiter and its address decoder.
// Holds slave codes, grant/ID encodings, decode windows and the FSM state type.
package bus_define;

  localparam logic [2:0] SLV_ROM     = 3'd1;
  localparam logic [2:0] SLV_IM      = 3'd2;
  localparam logic [2:0] SLV_DM      = 3'd3;
  localparam logic [2:0] SLV_SENSOR  = 3'd4;
  localparam logic [2:0] SLV_DRAM    = 3'd5;
  localparam logic [2:0] SLV_DEFAULT = 3'd6;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Upper-address windows compared against AWADDR[31:16], [31:10], [31:21]
  localparam logic [15:0] ROM_HI    = 16'h0000;
  localparam logic [15:0] IM_HI     = 16'h0001;
  localparam logic [15:0] DM_HI     = 16'h0002;
  localparam logic [21:0] SENSOR_HI = 22'h040000;
  localparam logic [10:0] DRAM_HI   = 11'h100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  // AWID control: bit3 = master (1 = M1), bits[2:0] = slave code
  function automatic logic [3:0] make_awid(input logic master, input logic [2:0] slv);
    return {master, slv};
  endfunction

endpackage

// File: rtl/axi_write_arbiter_addr_decoder.sv
// Combinational AXI address to slave-code decoder.
// Shared between the write and read arbiters.
module addr_decoder
  import bus_define::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        slave_code
);

  // Only the upper address bits select a slave
  logic unused_lo;
  assign unused_lo = ^addr[9:0];

  always_comb begin
    slave_code = SLV_DEFAULT;
    if      (addr[31:16] == ROM_HI)    slave_code = SLV_ROM;
    else if (addr[31:16] == IM_HI)     slave_code = SLV_IM;
    else if (addr[31:16] == DM_HI)     slave_code = SLV_DM;
    else if (addr[31:10] == SENSOR_HI) slave_code = SLV_SENSOR;
    else if (addr[31:21] == DRAM_HI)   slave_code = SLV_DRAM;
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Two-master AXI write arbiter: locks the grant from AW through the W burst to B,
// round-robins ties, and emits the AWID routing code for the crossbar muxes.
module axi_write_arbiter
  import bus_define::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR_M0,
  input  logic [ADDR_W-1:0] AWADDR_M1,
  input  logic              AWVALID_M0,
  input  logic              AWVALID_M1,
  input  logic [LEN_W-1:0]  AWLEN_M0,
  input  logic [LEN_W-1:0]  AWLEN_M1,
  input  logic              AWREADY_S,
  input  logic              WVALID_M,
  input  logic              WLAST_M,
  input  logic              WREADY_S,
  input  logic              BVALID_S,
  input  logic              BREADY_M,
  output logic [1:0]        Arbiter_Write_State_control,
  output logic [3:0]        Arbiter_AWID_control,
  output logic              aw_en,
  output logic              w_en,
  output logic              b_en,
  output logic              burst_err
);

  wr_state_e         state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        awid_q, awid_d;
  logic              err_q, err_d;
  logic              last_q, last_d;   // 1 = M1 was served last

  logic              gnt_m1;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        slave_code;
  logic              aw_hs;

  assign gnt_m1   = grant_q[1];
  assign sel_addr = gnt_m1 ? AWADDR_M1 : AWADDR_M0;
  assign aw_hs    = (gnt_m1 ? AWVALID_M1 : AWVALID_M0) && AWREADY_S;

  addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .addr       (sel_addr),
    .slave_code (slave_code)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      cnt_q   <= '0;
      awid_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      awid_q  <= awid_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    cnt_d                = cnt_q;
    awid_d               = awid_q;
    err_d                = 1'b0;
    last_d               = last_q;
    aw_en                = 1'b0;
    w_en                 = 1'b0;
    b_en                 = 1'b0;
    Arbiter_AWID_control = 4'b0000;
    unique case (state_q)
      IDLE: begin
        unique case ({AWVALID_M0, AWVALID_M1})
          2'b10:   grant_d = GNT_M0;
          2'b01:   grant_d = GNT_M1;
          2'b11:   grant_d = last_q ? GNT_M0 : GNT_M1;
          default: grant_d = GNT_NONE;
        endcase
        if (AWVALID_M0 || AWVALID_M1) state_d = ADDR;
      end
      ADDR: begin
        aw_en                = 1'b1;
        Arbiter_AWID_control = make_awid(gnt_m1, slave_code);
        if (aw_hs) begin
          cnt_d   = gnt_m1 ? AWLEN_M1 : AWLEN_M0;
          awid_d  = make_awid(gnt_m1, slave_code);
          state_d = DATA;
        end
      end
      DATA: begin
        w_en                 = 1'b1;
        Arbiter_AWID_control = awid_q;
        if (WVALID_M && WREADY_S) begin
          if (WLAST_M) begin
            err_d   = (cnt_q != '0);
            state_d = RESP;
          end else if (cnt_q == '0) begin
            // Too many beats: flag it, hold the counter at 0 and wait for WLAST
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      RESP: begin
        b_en                 = 1'b1;
        Arbiter_AWID_control = awid_q;
        if (BVALID_S && BREADY_M) begin
          last_d  = gnt_m1;
          grant_d = GNT_NONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Arbiter_Write_State_control = grant_q;
  assign burst_err                   = err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: grant, routing code, enables and burst checks
// against hand-computed output vectors {grant, awid, aw_en, w_en, b_en, burst_err}.
module tb_axi_write_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR_M0, AWADDR_M1;
  logic        AWVALID_M0, AWVALID_M1;
  logic [3:0]  AWLEN_M0, AWLEN_M1;
  logic        AWREADY_S, WVALID_M, WLAST_M, WREADY_S, BVALID_S, BREADY_M;
  logic [1:0]  grant;
  logic [3:0]  awid;
  logic        aw_en, w_en, b_en, burst_err;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_write_arbiter #(.ADDR_W(32), .LEN_W(4)) dut (
    .ACLK                        (ACLK),
    .ARESETn                     (ARESETn),
    .AWADDR_M0                   (AWADDR_M0),
    .AWADDR_M1                   (AWADDR_M1),
    .AWVALID_M0                  (AWVALID_M0),
    .AWVALID_M1                  (AWVALID_M1),
    .AWLEN_M0                    (AWLEN_M0),
    .AWLEN_M1                    (AWLEN_M1),
    .AWREADY_S                   (AWREADY_S),
    .WVALID_M                    (WVALID_M),
    .WLAST_M                     (WLAST_M),
    .WREADY_S                    (WREADY_S),
    .BVALID_S                    (BVALID_S),
    .BREADY_M                    (BREADY_M),
    .Arbiter_Write_State_control (grant),
    .Arbiter_AWID_control        (awid),
    .aw_en                       (aw_en),
    .w_en                        (w_en),
    .b_en                        (b_en),
    .burst_err                   (burst_err)
  );

  wire [9:0] outs = {grant, awid, aw_en, w_en, b_en, burst_err};

  function automatic logic [9:0] ex(input logic [1:0] g, input logic [3:0] id,
                                    input logic a, input logic w, input logic b, input logic e);
    return {g, id, a, w, b, e};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    checks++;
    assert (outs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
      end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETn = 1'b0;
    AWADDR_M0 = '0; AWADDR_M1 = '0; AWVALID_M0 = 0; AWVALID_M1 = 0;
    AWLEN_M0 = '0; AWLEN_M1 = '0; AWREADY_S = 0; WVALID_M = 0; WLAST_M = 0;
    WREADY_S = 0; BVALID_S = 0; BREADY_M = 0;
    repeat (2) @(posedge ACLK);
    #1 chk("reset", 10'b0);
    ARESETn = 1'b1;
    tick(); chk("idle_no_req", 10'b0);

    // Single write to DM, one beat
    AWADDR_M0 = 32'h0002_0010; AWLEN_M0 = 4'd0; AWVALID_M0 = 1; AWREADY_S = 1;
    tick(); chk("t1_addr", ex(2'b01, 4'b0011, 1, 0, 0, 0));
    tick(); chk("t1_data", ex(2'b01, 4'b0011, 0, 1, 0, 0));
    AWVALID_M0 = 0; AWREADY_S = 0; WVALID_M = 1; WLAST_M = 1; WREADY_S = 1;
    tick(); chk("t1_resp", ex(2'b01, 4'b0011, 0, 0, 1, 0));
    WVALID_M = 0; WLAST_M = 0; WREADY_S = 0; BVALID_S = 1; BREADY_M = 1;
    tick(); chk("t1_idle", 10'b0);
    BVALID_S = 0; BREADY_M = 0;

    // Both request with M0 served last -> M1; M0 stays pending until IDLE
    AWADDR_M0 = 32'h0000_0100; AWADDR_M1 = 32'h0001_0000; AWLEN_M0 = 0; AWLEN_M1 = 0;
    AWVALID_M0 = 1; AWVALID_M1 = 1; AWREADY_S = 0;
    tick(); chk("rr_m1_addr", ex(2'b10, 4'b1010, 1, 0, 0, 0));
    tick(); chk("addr_wait", ex(2'b10, 4'b1010, 1, 0, 0, 0));
    AWVALID_M1 = 0; AWREADY_S = 1;
    tick(); chk("addr_drop_hold", ex(2'b10, 4'b1010, 1, 0, 0, 0));
    AWVALID_M1 = 1;
    tick(); chk("m1_data", ex(2'b10, 4'b1010, 0, 1, 0, 0));
    AWVALID_M1 = 0; AWREADY_S = 0; WVALID_M = 1; WLAST_M = 1; WREADY_S = 1;
    tick(); chk("m1_resp", ex(2'b10, 4'b1010, 0, 0, 1, 0));
    WVALID_M = 0; WLAST_M = 0; WREADY_S = 0; BVALID_S = 1; BREADY_M = 1;
    tick(); chk("gap_idle", 10'b0);
    BVALID_S = 0; BREADY_M = 0;
    tick(); chk("rr_m0_addr", ex(2'b01, 4'b0001, 1, 0, 0, 0));
    AWREADY_S = 1;
    tick(); chk("m0_data", ex(2'b01, 4'b0001, 0, 1, 0, 0));
    AWVALID_M0 = 0; AWREADY_S = 0; WVALID_M = 1; WLAST_M = 1; WREADY_S = 1;
    tick(); chk("m0_resp", ex(2'b01, 4'b0001, 0, 0, 1, 0));
    WVALID_M = 0; WLAST_M = 0; WREADY_S = 0; BVALID_S = 1; BREADY_M = 1;
    tick(); chk("m0_idle", 10'b0);
    BVALID_S = 0; BREADY_M = 0;

    // DRAM burst of 4 with WREADY toggling
    AWADDR_M1 = 32'h2000_0100; AWLEN_M1 = 4'd3; AWVALID_M1 = 1; AWREADY_S = 1;
    tick(); chk("dram_addr", ex(2'b10, 4'b1101, 1, 0, 0, 0));
    tick(); chk("dram_data", ex(2'b10, 4'b1101, 0, 1, 0, 0));
    AWVALID_M1 = 0; AWREADY_S = 0; WVALID_M = 1;
    for (int i = 0; i < 8; i++) begin
      WREADY_S = i[0];
      WLAST_M  = (i == 7);
      tick();
      chk($sformatf("dram_beat%0d", i),
          (i < 7) ? ex(2'b10, 4'b1101, 0, 1, 0, 0) : ex(2'b10, 4'b1101, 0, 0, 1, 0));
    end
    WVALID_M = 0; WLAST_M = 0; WREADY_S = 0; BVALID_S = 1; BREADY_M = 1;
    tick(); chk("dram_idle", 10'b0);
    BVALID_S = 0; BREADY_M = 0;

    // Default slave, early WLAST on beat 2 of 4
    AWADDR_M0 = 32'h3000_0000; AWLEN_M0 = 4'd3; AWVALID_M0 = 1; AWREADY_S = 1;
    tick(); chk("dflt_addr", ex(2'b01, 4'b0110, 1, 0, 0, 0));
    tick(); chk("dflt_data", ex(2'b01, 4'b0110, 0, 1, 0, 0));
    AWVALID_M0 = 0; AWREADY_S = 0; WVALID_M = 1; WREADY_S = 1; WLAST_M = 0;
    tick(); chk("early_beat1", ex(2'b01, 4'b0110, 0, 1, 0, 0));
    WLAST_M = 1;
    tick(); chk("early_err", ex(2'b01, 4'b0110, 0, 0, 1, 1));
    WVALID_M = 0; WLAST_M = 0; WREADY_S = 0;
    tick(); chk("err_one_cycle", ex(2'b01, 4'b0110, 0, 0, 1, 0));
    BVALID_S = 1; BREADY_M = 1;
    tick(); chk("early_idle", 10'b0);
    BVALID_S = 0; BREADY_M = 0;

    // Extra beat past AWLEN 0: counter saturates, FSM waits for WLAST
    AWLEN_M0 = 4'd0; AWVALID_M0 = 1; AWREADY_S = 1;
    tick(); chk("sat_addr", ex(2'b01, 4'b0110, 1, 0, 0, 0));
    tick(); chk("sat_data", ex(2'b01, 4'b0110, 0, 1, 0, 0));
    AWVALID_M0 = 0; AWREADY_S = 0; WVALID_M = 1; WREADY_S = 1; WLAST_M = 0;
    tick(); chk("sat_err", ex(2'b01, 4'b0110, 0, 1, 0, 1));
    WLAST_M = 1;
    tick(); chk("sat_last", ex(2'b01, 4'b0110, 0, 0, 1, 0));
    WVALID_M = 0; WLAST_M = 0; WREADY_S = 0; BVALID_S = 1; BREADY_M = 1;
    tick(); chk("sat_idle", 10'b0);
    BVALID_S = 0; BREADY_M = 0;

    // Sensor write by M1, reset asserted mid-burst
    AWADDR_M1 = 32'h1000_0000; AWLEN_M1 = 4'd1; AWVALID_M1 = 1; AWREADY_S = 1;
    tick(); chk("sensor_addr", ex(2'b10, 4'b1100, 1, 0, 0, 0));
    tick(); chk("sensor_data", ex(2'b10, 4'b1100, 0, 1, 0, 0));
    AWVALID_M1 = 0; AWREADY_S = 0;
    #2 ARESETn = 1'b0;
    #1 chk("async_reset", 10'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    AWVALID_M0 = 1; AWVALID_M1 = 1;
    tick(); chk("post_reset_m0", ex(2'b01, 4'b0110, 1, 0, 0, 0));
    AWVALID_M0 = 0; AWVALID_M1 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
